// File: rtl/npc_inst_seq_ctrl_if.sv
// Instruction-memory fetch interface for the NPC sequencer.
// Request channel: imem_req_valid / imem_req_ready handshake carrying imem_addr.
// Response channel: imem_rsp_valid qualifies imem_rsp_data and has no backpressure.
// master: the sequencer (drives the request, receives the response).
// slave : the instruction memory.
interface npc_inst_seq_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/npc_inst_seq_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core.
// Fetches one instruction at a time over the imem interface, holds it on
// inst for the decoder, then steps DECODE -> EXEC -> WB from the decoder's
// class flags. Owns the PC and halts on ebreak, illegal opcode or fetch timeout.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   imem               fetch interface (master side)
//   inst               latched instruction to the decoder
//   is_addi, is_ebreak decoder class flags
//   ex_en, rf_wen      execute enable, register-file write enable
//   pc                 current PC (also drives imem_addr)
//   retire             one-cycle pulse per retired instruction
//   halt, halt_code    sticky halt and its cause (1 ebreak, 2 illegal, 3 timeout)
//   retire_cnt         retired-instruction counter
module npc_inst_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  npc_inst_seq_ctrl_if.master        imem,
  output logic [31:0]                inst,
  input  logic                       is_addi,
  input  logic                       is_ebreak,
  output logic                       ex_en,
  output logic                       rf_wen,
  output logic [63:0]                pc,
  output logic                       retire,
  output logic                       halt,
  output logic [1:0]                 halt_code,
  output logic [63:0]                retire_cnt
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_WAIT_RSP,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Last counter value before the timeout fires: after TIMEOUT response-less
  // WAIT_RSP cycles the FSM halts.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        req_valid;
  logic [15:0] tmo_cnt;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc;

  // Strobes are registered: each is set on the edge entering the state that
  // owns it and cleared by default otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      inst       <= '0;
      retire_cnt <= '0;
      halt       <= 1'b0;
      halt_code  <= 2'd0;
      req_valid  <= 1'b0;
      ex_en      <= 1'b0;
      rf_wen     <= 1'b0;
      retire     <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      req_valid <= 1'b0;
      ex_en     <= 1'b0;
      rf_wen    <= 1'b0;
      retire    <= 1'b0;
      case (state)
        S_RESET: begin
          state     <= S_FETCH;
          req_valid <= 1'b1;
        end
        S_FETCH: begin
          if (imem.imem_req_ready) begin
            state <= S_WAIT_RSP;
          end else begin
            req_valid <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          // Response is checked first so it wins over a coincident timeout.
          if (imem.imem_rsp_valid) begin
            inst    <= imem.imem_rsp_data;
            tmo_cnt <= '0;
            state   <= S_DECODE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt   <= '0;
            halt      <= 1'b1;
            halt_code <= 2'd3;
            state     <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (is_ebreak) begin
            // ebreak retires but does not advance the PC.
            halt       <= 1'b1;
            halt_code  <= 2'd1;
            retire     <= 1'b1;
            retire_cnt <= retire_cnt + 64'd1;
            state      <= S_HALT;
          end else if (is_addi) begin
            ex_en <= 1'b1;
            state <= S_EXEC;
          end else begin
            halt      <= 1'b1;
            halt_code <= 2'd2;
            state     <= S_HALT;
          end
        end
        S_EXEC: begin
          rf_wen     <= 1'b1;
          retire     <= 1'b1;
          retire_cnt <= retire_cnt + 64'd1;
          state      <= S_WB;
        end
        S_WB: begin
          pc        <= pc + 64'd4;
          req_valid <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_inst_seq_ctrl.sv
// Self-checking bench for npc_inst_seq_ctrl: directed scenarios plus a run of
// randomized addi instructions with random backpressure and response latency,
// checked against a transaction-level model of PC, retire count and halt cause.
module tb_npc_inst_seq_ctrl;
  localparam logic [63:0] RPC    = 64'h8000_0000;
  localparam int          TMO    = 16;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ILLEG  = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        is_addi, is_ebreak, force_addi;
  logic        ex_en, rf_wen, retire, halt;
  logic [63:0] pc, retire_cnt;
  logic [1:0]  halt_code;

  npc_inst_seq_ctrl_if imem ();

  npc_inst_seq_ctrl #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .inst       (inst),
    .is_addi    (is_addi),
    .is_ebreak  (is_ebreak),
    .ex_en      (ex_en),
    .rf_wen     (rf_wen),
    .pc         (pc),
    .retire     (retire),
    .halt       (halt),
    .halt_code  (halt_code),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  // Bench-side decoder.
  always_comb begin
    is_addi   = ((inst[6:0] == 7'h13) && (inst[14:12] == 3'b000)) || force_addi;
    is_ebreak = (inst == EBREAK);
  end

  // Pulse counters observed at the active edge.
  int rf_pulses = 0;
  int ret_pulses = 0;
  int handshakes = 0;
  always @(posedge clk) begin
    if (rf_wen) rf_pulses++;
    if (retire) ret_pulses++;
    if (imem.imem_req_valid && imem.imem_req_ready) handshakes++;
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] m_pc, m_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    force_addi = 1'b0;
    step();
    step();
    chk("rst_pc", pc, RPC);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_cnt", retire_cnt, 64'd0);
    chk("rst_halt", {62'd0, halt_code}, 64'd0);
    chk("rst_halt_flag", 64'(halt), 64'd0);
    chk("rst_strobes", {60'd0, imem.imem_req_valid, ex_en, rf_wen, retire}, 64'd0);
    rst_n = 1'b1;
    step();
    m_pc  = RPC;
    m_cnt = 64'd0;
    chk("first_req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("first_addr", imem.imem_addr, RPC);
  endtask

  // One full fetch/execute transaction starting at a FETCH-state negedge.
  // lat = WAIT_RSP cycle in which the response is given; lat > TMO means none.
  task automatic run_inst(input logic [31:0] word, input int rdly, input int lat);
    int rf0, ret0, hs0;
    bit ebr, add;
    rf0 = rf_pulses; ret0 = ret_pulses; hs0 = handshakes;
    chk("req_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("req_addr", imem.imem_addr, m_pc);
    for (int k = 0; k < rdly; k++) begin
      imem.imem_req_ready = 1'b0;
      step();
      chk("bp_valid", 64'(imem.imem_req_valid), 64'd1);
      chk("bp_addr", imem.imem_addr, m_pc);
    end
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    chk("valid_drop", 64'(imem.imem_req_valid), 64'd0);
    chk("one_handshake", 64'(handshakes - hs0), 64'd1);
    if (lat > TMO) begin
      for (int k = 1; k < TMO; k++) step();
      chk("no_early_tmo", 64'(halt), 64'd0);
      step();
      chk("tmo_halt", 64'(halt), 64'd1);
      chk("tmo_code", 64'(halt_code), 64'd3);
      chk("tmo_pc", pc, m_pc);
      chk("tmo_cnt", retire_cnt, m_cnt);
      chk("tmo_no_wr", 64'((rf_pulses - rf0) + (ret_pulses - ret0)), 64'd0);
      return;
    end
    for (int k = 1; k < lat; k++) step();
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = word;
    step();
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = $urandom;
    chk("inst_latch", 64'(inst), 64'(word));
    ebr = (word == EBREAK);
    add = force_addi || (word[6:0] == 7'h13 && word[14:12] == 3'b000);
    if (ebr) begin
      step();
      chk("ebk_halt", 64'(halt), 64'd1);
      chk("ebk_code", 64'(halt_code), 64'd1);
      chk("ebk_retire", 64'(retire), 64'd1);
      m_cnt = m_cnt + 64'd1;
      chk("ebk_cnt", retire_cnt, m_cnt);
      chk("ebk_pc", pc, m_pc);
    end else if (add) begin
      // Stray responses outside WAIT_RSP must not disturb inst.
      imem.imem_rsp_valid = 1'($urandom);
      step();
      chk("ex_en", 64'(ex_en), 64'd1);
      chk("ex_no_wen", 64'(rf_wen), 64'd0);
      step();
      chk("wb_wen_retire", {62'd0, rf_wen, retire}, 64'd3);
      m_cnt = m_cnt + 64'd1;
      chk("wb_cnt", retire_cnt, m_cnt);
      chk("wb_inst_stable", 64'(inst), 64'(word));
      chk("wb_pc", pc, m_pc);
      step();
      imem.imem_rsp_valid = 1'b0;
      m_pc = m_pc + 64'd4;
      chk("next_fetch", {63'd0, imem.imem_req_valid}, 64'd1);
      chk("next_pc", pc, m_pc);
      chk("wen_once", 64'(rf_pulses - rf0), 64'd1);
    end else begin
      step();
      chk("ill_halt", 64'(halt), 64'd1);
      chk("ill_code", 64'(halt_code), 64'd2);
      chk("ill_cnt", retire_cnt, m_cnt);
      chk("ill_no_wr", 64'((rf_pulses - rf0) + (ret_pulses - ret0)), 64'd0);
    end
  endtask

  task automatic check_halted(input int n);
    for (int k = 0; k < n; k++) begin
      imem.imem_rsp_valid = 1'($urandom);
      imem.imem_req_ready = 1'($urandom);
      step();
      chk("halt_no_req", 64'(imem.imem_req_valid), 64'd0);
      chk("halt_pc", pc, m_pc);
      chk("halt_sticky", 64'(halt), 64'd1);
      chk("halt_quiet", {61'd0, ex_en, rf_wen, retire}, 64'd0);
    end
    imem.imem_rsp_valid = 1'b0;
    imem.imem_req_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    do_reset();

    // Three back-to-back addi.
    for (int i = 0; i < 3; i++) run_inst(ADDI, 0, 1);
    chk("t1_cnt", retire_cnt, 64'd3);

    // Backpressure and late (but in-time) responses, including the boundary.
    run_inst(ADDI, 4, 10);
    run_inst(ADDI, 0, TMO);

    // Randomized addi stream.
    for (int i = 0; i < 40; i++) begin
      w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
      run_inst(w, int'($urandom_range(0, 4)), int'($urandom_range(1, TMO)));
    end

    // Timeout.
    do_reset();
    run_inst(ADDI, 1, TMO + 1);
    check_halted(4);

    // ebreak after one addi.
    do_reset();
    run_inst(ADDI, 0, 1);
    run_inst(EBREAK, 0, 1);
    chk("t4_cnt", retire_cnt, 64'd2);
    chk("t4_pc", pc, RPC + 64'd4);
    check_halted(6);

    // Illegal instruction, then reset recovery.
    do_reset();
    run_inst(ILLEG, 2, 3);
    check_halted(4);
    do_reset();

    // Both flags set: ebreak takes priority.
    force_addi = 1'b1;
    run_inst(EBREAK, 0, 2);
    force_addi = 1'b0;
    check_halted(2);

    // Reset in WAIT_RSP, late response in the following cycle is ignored.
    do_reset();
    imem.imem_req_ready = 1'b1;
    step();
    imem.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = ADDI;
    step();
    imem.imem_rsp_valid = 1'b0;
    chk("t6_inst", 64'(inst), 64'd0);
    chk("t6_valid", 64'(imem.imem_req_valid), 64'd1);
    chk("t6_addr", imem.imem_addr, RPC);
    chk("t6_cnt", retire_cnt, 64'd0);
    m_pc  = RPC;
    m_cnt = 64'd0;
    run_inst(ADDI, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/npc_inst_seq_ctrl.md
Name: npc_inst_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core. It fetches one instruction from instruction memory over a valid/ready request and valid response interface, then holds it stable for the instruction decoder. It sequences decode, execute and register-file writeback from the decoder's class flags, owns the PC, and halts the core on ebreak, an illegal instruction or a fetch timeout.

Parameters:
RESET_PC, 64'h8000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles to wait for a fetch response before an error halt (range 1..65535)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_addr  out  64  fetch address, equal to pc
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction
inst  out  32  latched instruction, feeds the decoder
is_addi  in  1  decoder flag: addi
is_ebreak  in  1  decoder flag: ebreak (32'h0010_0073)
ex_en  out  1  execute-stage enable (ALU operand latch)
rf_wen  out  1  register-file write enable
pc  out  64  current PC
retire  out  1  one-cycle pulse per retired instruction
halt  out  1  core halted (sticky)
halt_code  out  2  0 = none, 1 = ebreak, 2 = illegal, 3 = fetch timeout
retire_cnt  out  64  retired-instruction counter

Behaviour:
- Reset (rst_n low at a clk edge, any state):
  - state = RESET; pc = RESET_PC; inst = 0; retire_cnt = 0; halt = 0; halt_code = 0.
  - All strobes (imem_req_valid, ex_en, rf_wen, retire) = 0; timeout counter = 0.
  - A reset mid-fetch abandons the transaction. A late imem_rsp_valid after reset is ignored unless the FSM is in WAIT_RSP.
- States and transitions:
  - RESET -> FETCH, unconditionally, one cycle after rst_n goes high.
  - FETCH:
    - imem_req_valid = 1; imem_addr = pc.
    - Advance to WAIT_RSP on a cycle where imem_req_valid && imem_req_ready.
    - Otherwise stay in FETCH, holding valid and addr stable.
  - WAIT_RSP:
    - On imem_rsp_valid: latch inst = imem_rsp_data, go to DECODE.
    - Timeout counter increments each cycle without a response. When it reaches TIMEOUT, go to HALT with halt_code = 3.
    - The counter clears on leaving WAIT_RSP.
    - A response in the same cycle the counter reaches TIMEOUT counts as accepted (response wins).
  - DECODE:
    - One cycle; decoder outputs are sampled at the end of the cycle.
    - is_ebreak -> HALT with halt_code = 1.
    - else is_addi -> EXEC.
    - else -> HALT with halt_code = 2.
    - If both flags are set, ebreak wins.
  - EXEC: ex_en = 1 for exactly one cycle, then WB.
  - WB:
    - rf_wen = 1 and retire = 1 for one cycle.
    - pc <= pc + 4, wrapping modulo 2^64.
    - retire_cnt increments, wrapping modulo 2^64.
    - Next state FETCH.
  - HALT:
    - halt = 1, sticky until reset.
    - No requests, no writes; pc and inst hold.
    - An ebreak halt still counts as retired: retire pulses once and retire_cnt increments on entry. pc does not advance.
    - Illegal and timeout halts do not retire.
- Latency: with imem_req_ready = 1 and a response one cycle later, one addi takes 5 cycles (FETCH, WAIT_RSP, DECODE, EXEC, WB). The next fetch request follows WB back-to-back.
- Only one outstanding fetch at a time. imem_rsp_valid outside WAIT_RSP is ignored.
- inst changes only on the WAIT_RSP-to-DECODE transition and is stable through DECODE, EXEC and WB.
- All outputs are registered or decoded from state only; there is no combinational path from imem_* inputs to outputs.

Test Plan:
1. Reset then three addi (0x00100093 each), ready = 1, response latency 1 -> first imem_addr = 0x80000000. Requests are issued at 0x80000000, 0x80000004, 0x80000008. Each instruction takes 5 cycles with one rf_wen pulse; retire_cnt = 3.
2. Backpressure: imem_req_ready low for 4 cycles -> imem_req_valid stays high with addr unchanged, and there is exactly one handshake. Response delayed 10 cycles with TIMEOUT = 16 -> no timeout; the instruction completes normally.
3. No response for 16 cycles -> halt = 1 and halt_code = 3 at cycle 16 of WAIT_RSP. No rf_wen or retire; pc is unchanged.
4. Fetch ebreak 0x00100073 after one addi -> halt_code = 1 and retire_cnt = 2. pc holds 0x80000004, and no further imem_req_valid is issued.
5. Fetch 0x00000033 (neither flag set) -> halt_code = 2, retire_cnt unchanged, rf_wen never asserted. A later rst_n pulse restores pc = 0x80000000 and halt = 0.
6. Assert rst_n low during WAIT_RSP while a response is pending, and drive the response in the following cycle -> the response is ignored. The FSM restarts, and its first fetch after reset is at RESET_PC with retire_cnt = 0.
